// File: rtl/SB_codex_pkg.sv
// Sideband message type and the MBINIT request/response codes, with the
// PARAM_CONFIG data field layout shared by the MBINIT responder.
package SB_codex_pkg;

   typedef struct packed {
      logic [7:0]  msgcode;
      logic [7:0]  msgsubcode;
      logic [63:0] data;
   } SB_msg_t;

   // {msgcode, msgsubcode} pairs for the five MBINIT request/response messages
   localparam logic [15:0] MBINIT_PARAM_CONFIG_REQ     = {8'hA5, 8'h00};
   localparam logic [15:0] MBINIT_PARAM_CONFIG_RESP    = {8'hAA, 8'h00};
   localparam logic [15:0] MBINIT_CAL_DONE_REQ         = {8'hA5, 8'h02};
   localparam logic [15:0] MBINIT_CAL_DONE_RESP        = {8'hAA, 8'h02};
   localparam logic [15:0] MBINIT_REPAIRCLK_INIT_REQ   = {8'hA5, 8'h03};
   localparam logic [15:0] MBINIT_REPAIRCLK_INIT_RESP  = {8'hAA, 8'h03};
   localparam logic [15:0] MBINIT_REPAIRCLK_RESULT_REQ = {8'hA5, 8'h04};
   localparam logic [15:0] MBINIT_REPAIRCLK_RESULT_RESP= {8'hAA, 8'h04};
   localparam logic [15:0] MBINIT_REPAIRCLK_DONE_REQ   = {8'hA5, 8'h08};
   localparam logic [15:0] MBINIT_REPAIRCLK_DONE_RESP  = {8'hAA, 8'h08};

   // PARAM_CONFIG data field positions
   localparam int PARAM_RATE_LSB     = 0;
   localparam int PARAM_RATE_MSB     = 2;
   localparam int PARAM_CLK_MODE_BIT = 3;

   localparam logic [2:0] LAST_STEP = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SEND,
      ST_DONE,
      ST_ERROR
   } mbinit_rsp_state_t;

   // Request expected at a given handshake step
   function automatic logic [15:0] mbinit_exp_req(input logic [2:0] step);
      case (step)
         3'd0:    mbinit_exp_req = MBINIT_PARAM_CONFIG_REQ;
         3'd1:    mbinit_exp_req = MBINIT_CAL_DONE_REQ;
         3'd2:    mbinit_exp_req = MBINIT_REPAIRCLK_INIT_REQ;
         3'd3:    mbinit_exp_req = MBINIT_REPAIRCLK_RESULT_REQ;
         default: mbinit_exp_req = MBINIT_REPAIRCLK_DONE_REQ;
      endcase
   endfunction

   // Response returned at a given handshake step
   function automatic logic [15:0] mbinit_resp_code(input logic [2:0] step);
      case (step)
         3'd0:    mbinit_resp_code = MBINIT_PARAM_CONFIG_RESP;
         3'd1:    mbinit_resp_code = MBINIT_CAL_DONE_RESP;
         3'd2:    mbinit_resp_code = MBINIT_REPAIRCLK_INIT_RESP;
         3'd3:    mbinit_resp_code = MBINIT_REPAIRCLK_RESULT_RESP;
         default: mbinit_resp_code = MBINIT_REPAIRCLK_DONE_RESP;
      endcase
   endfunction

endpackage

// File: rtl/mbinit_param_negotiator.sv
// Rate / clock-mode negotiation: combinational min/AND feeding the response,
// plus a registered copy of the agreed values.
module mbinit_param_negotiator (
   input  logic       clk,
   input  logic       clr,
   input  logic       load,
   input  logic [2:0] local_rate,
   input  logic       local_mode,
   input  logic [2:0] partner_rate,
   input  logic       partner_mode,
   output logic [2:0] resp_rate,
   output logic       resp_mode,
   output logic [2:0] neg_rate,
   output logic       neg_mode,
   output logic       neg_valid
);

   assign resp_rate = (partner_rate < local_rate) ? partner_rate : local_rate;
   assign resp_mode = local_mode & partner_mode;

   // Latch the agreed values when the PARAM request is consumed
   always_ff @(posedge clk) begin
      if (clr) begin
         neg_rate  <= '0;
         neg_mode  <= 1'b0;
         neg_valid <= 1'b0;
      end else if (load) begin
         neg_rate  <= resp_rate;
         neg_mode  <= resp_mode;
         neg_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/mbinit_sb_responder.sv
// MBINIT partner-side sideband responder: answers the five MBINIT requests in
// order, negotiating rate/clock mode and reporting clock-lane detection.
// Optional macro MBINIT_RESP_TIMEOUT_EN: ERROR after TIMEOUT_CYCLES idle WAIT cycles.
module mbinit_sb_responder
   import SB_codex_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 800000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       enable_i,
   input  logic [2:0] local_max_rate_i,
   input  logic       local_clk_mode_i,
   input  logic [1:0] rx_clk_detect_i,
   input  SB_msg_t    RX_msg_i,
   input  logic       RX_msg_valid_i,
   output logic       RX_msg_req_o,
   output SB_msg_t    TX_msg_o,
   output logic       TX_msg_valid_o,
   output logic [2:0] negotiated_rate_o,
   output logic       negotiated_clk_mode_o,
   output logic       negotiated_valid_o,
   output logic       responder_done_o,
   output logic       responder_error_o
);

   mbinit_rsp_state_t state, state_nxt;
   logic [2:0]  step, step_nxt;
   logic        consume, timeout, tx_load, neg_load, clr;
   logic [2:0]  resp_rate;
   logic        resp_mode;
   logic [63:0] resp_data;
   SB_msg_t     tx_nxt;

   assign clr     = reset || !enable_i;
   assign consume = RX_msg_valid_i && RX_msg_req_o;

   mbinit_param_negotiator u_neg (
      .clk          (clk_100MHz),
      .clr          (clr),
      .load         (neg_load),
      .local_rate   (local_max_rate_i),
      .local_mode   (local_clk_mode_i),
      .partner_rate (RX_msg_i.data[PARAM_RATE_MSB:PARAM_RATE_LSB]),
      .partner_mode (RX_msg_i.data[PARAM_CLK_MODE_BIT]),
      .resp_rate    (resp_rate),
      .resp_mode    (resp_mode),
      .neg_rate     (negotiated_rate_o),
      .neg_mode     (negotiated_clk_mode_o),
      .neg_valid    (negotiated_valid_o)
   );

`ifdef MBINIT_RESP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   // Count WAIT cycles; any other state clears so each WAIT entry starts at 0
   always_ff @(posedge clk_100MHz) begin
      if (reset || state != ST_WAIT) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Response payload for the current step
   always_comb begin
      resp_data = '0;
      case (step)
         3'd0: begin
            resp_data[PARAM_RATE_MSB:PARAM_RATE_LSB] = resp_rate;
            resp_data[PARAM_CLK_MODE_BIT]            = resp_mode;
         end
         3'd3:    resp_data[1:0] = rx_clk_detect_i;
         default: ;
      endcase
   end

   // Next-state, step advance and response load
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      tx_load   = 1'b0;
      neg_load  = 1'b0;
      tx_nxt    = TX_msg_o;
      case (state)
         ST_IDLE: begin
            state_nxt = ST_WAIT;
            step_nxt  = '0;
         end
         ST_WAIT: begin
            if (consume) begin
               if ({RX_msg_i.msgcode, RX_msg_i.msgsubcode} == mbinit_exp_req(step)) begin
                  state_nxt = ST_SEND;
                  tx_load   = 1'b1;
                  neg_load  = (step == 3'd0);
                  {tx_nxt.msgcode, tx_nxt.msgsubcode} = mbinit_resp_code(step);
                  tx_nxt.data = resp_data;
               end else begin
                  state_nxt = ST_ERROR;
               end
            end else if (timeout) begin
               state_nxt = ST_ERROR;
            end
         end
         ST_SEND: begin
            if (step == LAST_STEP) state_nxt = ST_DONE;
            else begin
               state_nxt = ST_WAIT;
               step_nxt  = step + 3'd1;
            end
         end
         default: ;
      endcase
      if (!enable_i) begin
         state_nxt = ST_IDLE;
         step_nxt  = '0;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk_100MHz) begin
      if (clr) begin
         state             <= ST_IDLE;
         step              <= '0;
         RX_msg_req_o      <= 1'b0;
         TX_msg_o          <= '0;
         TX_msg_valid_o    <= 1'b0;
         responder_done_o  <= 1'b0;
         responder_error_o <= 1'b0;
      end else begin
         state             <= state_nxt;
         step              <= step_nxt;
         RX_msg_req_o      <= (state_nxt == ST_WAIT);
         TX_msg_valid_o    <= tx_load;
         if (tx_load) TX_msg_o <= tx_nxt;
         responder_done_o  <= (state_nxt == ST_DONE);
         responder_error_o <= (state_nxt == ST_ERROR);
      end
   end

endmodule

// File: tb/tb_mbinit_sb_responder.sv
// Directed bench for mbinit_sb_responder: reset, full sequence, negotiation,
// clock report, out-of-order error, enable drop/restart, timeout.
module tb_mbinit_sb_responder;
   import SB_codex_pkg::*;

   logic       clk_100MHz = 1'b0;
   logic       reset, enable;
   logic [2:0] local_rate;
   logic       local_mode;
   logic [1:0] rx_clk_detect;
   SB_msg_t    rx_msg;
   logic       rx_valid;
   logic       rx_req;
   SB_msg_t    tx_msg;
   logic       tx_valid;
   logic [2:0] neg_rate;
   logic       neg_mode, neg_valid, done, err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   mbinit_sb_responder #(.TIMEOUT_CYCLES(16)) dut (
      .clk_100MHz            (clk_100MHz),
      .reset                 (reset),
      .enable_i              (enable),
      .local_max_rate_i      (local_rate),
      .local_clk_mode_i      (local_mode),
      .rx_clk_detect_i       (rx_clk_detect),
      .RX_msg_i              (rx_msg),
      .RX_msg_valid_i        (rx_valid),
      .RX_msg_req_o          (rx_req),
      .TX_msg_o              (tx_msg),
      .TX_msg_valid_o        (tx_valid),
      .negotiated_rate_o     (neg_rate),
      .negotiated_clk_mode_o (neg_mode),
      .negotiated_valid_o    (neg_valid),
      .responder_done_o      (done),
      .responder_error_o     (err)
   );

   // Waits (bounded) for the request level, presents one message for one
   // cycle and returns at the negedge of the following (response) cycle.
   task automatic drive_req(input logic [7:0] code, input logic [7:0] sub,
                            input logic [63:0] data);
      int w = 0;
      while (rx_req !== 1'b1 && w < 20) begin
         @(negedge clk_100MHz);
         w++;
      end
      n_vec++;
      if (rx_req !== 1'b1) begin
         n_err++;
         $display("FAIL req_wait: RX_msg_req_o=%b required 1", rx_req);
      end
      rx_msg.msgcode    = code;
      rx_msg.msgsubcode = sub;
      rx_msg.data       = data;
      rx_valid          = 1'b1;
      @(negedge clk_100MHz);
      rx_valid = 1'b0;
      rx_msg   = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; rx_valid = 1'b1;
      rx_msg = '{msgcode: 8'hA5, msgsubcode: 8'h00, data: 64'hF};
      repeat (3) @(negedge clk_100MHz);
      n_vec++;
      if ({rx_req, tx_valid, neg_valid, done, err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: req/txv/negv/done/err=%b required 00000",
                  {rx_req, tx_valid, neg_valid, done, err});
      end
      n_vec++;
      if (tx_msg !== '0 || neg_rate !== 3'd0 || neg_mode !== 1'b0) begin
         n_err++;
         $display("FAIL reset_data: tx=%h rate=%0d mode=%b required 0", tx_msg, neg_rate, neg_mode);
      end
      rx_valid = 1'b0; rx_msg = '0; enable = 1'b0;
      @(negedge clk_100MHz);
      reset = 1'b0;
      @(negedge clk_100MHz);
   endtask

   task automatic test_full_sequence;
      logic [7:0]  sub_tbl  [1:4];
      logic [63:0] data_tbl [1:4];
      sub_tbl[1] = 8'h02; sub_tbl[2] = 8'h03; sub_tbl[3] = 8'h04; sub_tbl[4] = 8'h08;
      data_tbl[1] = 64'h0; data_tbl[2] = 64'h0; data_tbl[3] = 64'h2; data_tbl[4] = 64'h0;
      local_rate = 3'd5; local_mode = 1'b0; rx_clk_detect = 2'b00;
      enable = 1'b1;
      // step 0: partner rate 3, mode 1, junk in upper bits
      drive_req(8'hA5, 8'h00, 64'h1234_0000_0000_000B);
      n_vec++;
      if (tx_valid !== 1'b1 || tx_msg.msgcode !== 8'hAA || tx_msg.msgsubcode !== 8'h00) begin
         n_err++;
         $display("FAIL param_resp: v=%b code=%h/%h required 1 AA/00", tx_valid, tx_msg.msgcode, tx_msg.msgsubcode);
      end
      n_vec++;
      if (tx_msg.data !== 64'h3) begin
         n_err++;
         $display("FAIL param_data: %h required 3", tx_msg.data);
      end
      n_vec++;
      if (neg_rate !== 3'd3 || neg_mode !== 1'b0 || neg_valid !== 1'b1 || rx_req !== 1'b0) begin
         n_err++;
         $display("FAIL negotiated: rate=%0d mode=%b valid=%b req=%b required 3 0 1 0",
                  neg_rate, neg_mode, neg_valid, rx_req);
      end
      @(negedge clk_100MHz);
      n_vec++;
      if (tx_valid !== 1'b0 || rx_req !== 1'b1) begin
         n_err++;
         $display("FAIL pulse_width: txv=%b req=%b required 0 1", tx_valid, rx_req);
      end
      for (int s = 1; s <= 4; s++) begin
         if (s == 3) rx_clk_detect = 2'b10;
         drive_req(8'hA5, sub_tbl[s], 64'h0);
         rx_clk_detect = 2'b00;
         n_vec++;
         if (tx_valid !== 1'b1 || tx_msg.msgcode !== 8'hAA || tx_msg.msgsubcode !== sub_tbl[s]
             || tx_msg.data !== data_tbl[s]) begin
            n_err++;
            $display("FAIL step%0d_resp: v=%b msg=%h/%h data=%h required 1 AA/%h data=%h",
                     s, tx_valid, tx_msg.msgcode, tx_msg.msgsubcode, tx_msg.data, sub_tbl[s], data_tbl[s]);
         end
      end
      @(negedge clk_100MHz);
      n_vec++;
      if (done !== 1'b1 || rx_req !== 1'b0 || tx_valid !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL done_rise: done=%b req=%b txv=%b err=%b required 1 0 0 0", done, rx_req, tx_valid, err);
      end
      repeat (3) @(negedge clk_100MHz);
      n_vec++;
      if (done !== 1'b1 || tx_msg.msgsubcode !== 8'h08 || neg_rate !== 3'd3) begin
         n_err++;
         $display("FAIL done_hold: done=%b sub=%h rate=%0d required 1 08 3", done, tx_msg.msgsubcode, neg_rate);
      end
   endtask

   task automatic test_drop_enable;
      enable = 1'b0;
      repeat (2) @(negedge clk_100MHz);
      n_vec++;
      if (done !== 1'b0 || neg_valid !== 1'b0) begin
         n_err++;
         $display("FAIL done_clear: done=%b negv=%b required 0 0", done, neg_valid);
      end
      enable = 1'b1;
      drive_req(8'hA5, 8'h00, 64'hB);
      drive_req(8'hA5, 8'h02, 64'h0);
      @(negedge clk_100MHz);
      // now waiting in step 2
      enable = 1'b0;
      @(negedge clk_100MHz);
      n_vec++;
      if ({rx_req, tx_valid, neg_valid, done, err} !== 5'b0 || tx_msg !== '0 || neg_rate !== 3'd0) begin
         n_err++;
         $display("FAIL enable_drop: flags=%b tx=%h rate=%0d required all 0",
                  {rx_req, tx_valid, neg_valid, done, err}, tx_msg, neg_rate);
      end
      local_rate = 3'd2; local_mode = 1'b1;
      enable = 1'b1;
      drive_req(8'hA5, 8'h00, 64'hE);   // partner rate 6, mode 1
      n_vec++;
      if (tx_valid !== 1'b1 || tx_msg.msgsubcode !== 8'h00 || tx_msg.data !== 64'hA || err !== 1'b0) begin
         n_err++;
         $display("FAIL restart_step0: v=%b sub=%h data=%h err=%b required 1 00 A 0",
                  tx_valid, tx_msg.msgsubcode, tx_msg.data, err);
      end
      n_vec++;
      if (neg_rate !== 3'd2 || neg_mode !== 1'b1) begin
         n_err++;
         $display("FAIL restart_neg: rate=%0d mode=%b required 2 1", neg_rate, neg_mode);
      end
   endtask

   task automatic test_out_of_order;
      enable = 1'b0;
      @(negedge clk_100MHz);
      enable = 1'b1;
      drive_req(8'hA5, 8'h02, 64'h0);   // CAL_DONE in step 0
      n_vec++;
      if (tx_valid !== 1'b0 || err !== 1'b1 || rx_req !== 1'b0) begin
         n_err++;
         $display("FAIL ooo_error: txv=%b err=%b req=%b required 0 1 0", tx_valid, err, rx_req);
      end
      repeat (3) @(negedge clk_100MHz);
      n_vec++;
      if (err !== 1'b1 || tx_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ooo_hold: err=%b txv=%b required 1 0", err, tx_valid);
      end
      enable = 1'b0;
      @(negedge clk_100MHz);
      n_vec++;
      if (err !== 1'b0) begin
         n_err++;
         $display("FAIL ooo_clear: err=%b required 0", err);
      end
   endtask

   task automatic test_timeout;
      enable = 1'b0;
      @(negedge clk_100MHz);
      enable = 1'b1;
`ifdef MBINIT_RESP_TIMEOUT_EN
      // WAIT entered at the first edge; 16 WAIT cycles then ERROR
      repeat (16) @(negedge clk_100MHz);
      n_vec++;
      if (err !== 1'b0 || rx_req !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_early: err=%b req=%b required 0 1", err, rx_req);
      end
      @(negedge clk_100MHz);
      n_vec++;
      if (err !== 1'b1 || rx_req !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_err: err=%b req=%b required 1 0", err, rx_req);
      end
`else
      repeat (40) @(negedge clk_100MHz);
      n_vec++;
      if (err !== 1'b0 || rx_req !== 1'b1) begin
         n_err++;
         $display("FAIL no_timeout: err=%b req=%b required 0 1", err, rx_req);
      end
`endif
      enable = 1'b0;
      @(negedge clk_100MHz);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; local_rate = '0; local_mode = 1'b0;
      rx_clk_detect = '0; rx_msg = '0; rx_valid = 1'b0;
      @(negedge clk_100MHz);
      test_reset;
      test_full_sequence;
      test_drop_enable;
      test_out_of_order;
      test_timeout;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mbinit_sb_responder.md
# mbinit_sb_responder

Partner-side sideband responder for the MBINIT phase of the logical PHY link training state machine. It consumes MBINIT request messages sent by the remote die's initiator. For each one it returns the matching response message, negotiating link parameters and reporting local clock-lane detection. It sits beside the MBINIT initiator on the same sideband TX/RX message ports, and LTSM gates it with `enable_i`.

## Interface
- `TIMEOUT_CYCLES`, default 800000: sideband wait limit in clk_100MHz cycles (8 ms).
- `clk_100MHz`  in  1  sideband clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  LTSM grants the MBINIT responder role; low forces IDLE.
- `local_max_rate_i`  in  3  local maximum data-rate code.
- `local_clk_mode_i`  in  1  local clock mode: 1 = continuous, 0 = strobe.
- `rx_clk_detect_i`  in  2  clock pins seen toggling, already synchronized to clk_100MHz.
- `RX_msg_i`  in  SB_msg_t  received sideband message.
- `RX_msg_valid_i`  in  1  `RX_msg_i` valid.
- `RX_msg_req_o`  out  1  responder ready to consume one message.
- `TX_msg_o`  out  SB_msg_t  response message.
- `TX_msg_valid_o`  out  1  one-cycle pulse; the sideband TX always accepts it.
- `negotiated_rate_o`  out  3  agreed rate code.
- `negotiated_clk_mode_o`  out  1  agreed clock mode.
- `negotiated_valid_o`  out  1  negotiated values are valid.
- `responder_done_o`  out  1  all MBINIT responses sent.
- `responder_error_o`  out  1  protocol error or timeout.

## Operation
- SB_msg_t fields used: `msgcode[7:0]`, `msgsubcode[7:0]`, `data[63:0]`.
- States:
  - IDLE
  - WAIT (step 0..4)
  - SEND
  - DONE
  - ERROR
- Step 0, PARAM_CONFIG_REQ → PARAM_CONFIG_RESP:
  - Request data: `data[2:0]` is the partner rate, `data[3]` is the partner clock mode.
  - Response rate is the unsigned minimum of local and partner rate.
  - Response clock mode is local AND partner.
  - Response data carries rate in `[2:0]` and mode in `[3]`, with all other bits 0.
  - The result is latched into the `negotiated_*` outputs and `negotiated_valid_o` is set.
- Step 1, CAL_DONE_REQ → CAL_DONE_RESP, data 0.
- Step 2, REPAIRCLK_INIT_REQ → REPAIRCLK_INIT_RESP, data 0.
- Step 3, REPAIRCLK_RESULT_REQ → REPAIRCLK_RESULT_RESP:
  - `data[1:0]` = `rx_clk_detect_i`, sampled in the consume cycle.
  - Other data bits are 0.
- Step 4, REPAIRCLK_DONE_REQ → REPAIRCLK_DONE_RESP, data 0; the FSM then goes to DONE.
- Transitions:
  - IDLE → WAIT(0) when `enable_i` = 1.
  - WAIT consumes a message when `RX_msg_valid_i && RX_msg_req_o`.
    - If the msgcode/msgsubcode pair equals the step's expected request: go to SEND.
    - Otherwise: go to ERROR.
  - SEND → WAIT(step+1), or DONE after step 4.
  - DONE and ERROR hold until `enable_i` = 0.
- `enable_i` = 0 in any state, or `reset`:
  - Next state is IDLE and the step counter returns to 0.
  - All outputs are cleared, including `negotiated_*`, done and error.
- `RX_msg_valid_i` while `RX_msg_req_o` = 0 is ignored; no state change.

## Timing
- Reset value of every output is 0, including `TX_msg_o` (all fields 0).
- `RX_msg_req_o` is a registered level, 1 only in WAIT.
- Request/response latency: a request consumed in cycle N gives `TX_msg_valid_o` = 1 with the response in cycle N+1 (SEND).
  - `RX_msg_req_o` is 0 in N+1 and returns to 1 in N+2.
- `TX_msg_o` holds its last value after the pulse.
- `negotiated_*` update in cycle N+1, together with the PARAM response.
- `responder_done_o` rises in the cycle after the step-4 SEND.
- `responder_error_o` rises in the cycle after the offending consume or timeout.

## Configuration
- `MBINIT_RESP_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES-1 without a consume sends the FSM to ERROR.
- Undefined: no counter, and WAIT waits indefinitely.

## Structure
- Add the following to SB_codex_pkg:
  - msgcode/msgsubcode constants for all ten MBINIT request/response messages.
  - The PARAM data field bit positions.
- One natural sub-module, `mbinit_param_negotiator`: combinational min/AND of rate and clock mode, with a registered result.

## Test plan
- Full sequence, steps 0..4 in order:
  - Each request gives one `TX_msg_valid_o` pulse exactly 1 cycle after consume, with the matching response code.
  - `responder_done_o` = 1 after step 4.
- Negotiation, local rate 5, partner rate 3 and mode 1, local mode 0:
  - Response data = 0x3.
  - `negotiated_rate_o` = 3, `negotiated_clk_mode_o` = 0.
- Clock report, `rx_clk_detect_i` = 2'b10 at step 3 → RESULT_RESP `data[1:0]` = 2'b10.
- Out-of-order request, CAL_DONE_REQ in step 0:
  - No TX pulse.
  - `responder_error_o` = 1 the next cycle, held until `enable_i` = 0.
- `enable_i` dropped during step 2, then re-raised:
  - All outputs return to 0.
  - The FSM restarts at step 0.
- With `MBINIT_RESP_TIMEOUT_EN` and TIMEOUT_CYCLES = 16: no message for 16 WAIT cycles → error asserted; without the macro there is no error.
